dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the memory-access stage; consumes its dmem_addr/dmem_wdata/dmem_read_en/dmem_write_en and returns dmem_rdata.
- Holds a word-addressed data array with a programmable number of wait states, and stalls the pipeline (drives the EX/MEM and upstream enable low) until each access completes.
- Flags misaligned accesses and counts stall cycles for performance monitoring.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, 16..65536.
- WAIT_STATES, 2: extra cycles per aligned access; 0..15.
- IDX_W, log2(DEPTH_WORDS): word-index width (derived, not overridden).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_addr  in  32  byte address from the memory stage (dmem_addr).
- req_wdata  in  32  store data (dmem_wdata).
- req_read_en  in  1  load request (dmem_read_en).
- req_write_en  in  1  store request (dmem_write_en).
- rdata  out  32  load data to the memory stage (dmem_rdata).
- stall  out  1  1 = pipeline must hold; EX/MEM contents stay constant while high.
- align_err  out  1  one-cycle pulse on a misaligned request.
- stall_cycles  out  32  saturating count of cycles with stall=1.

Behaviour:
- Request: req = req_read_en | req_write_en. If both are high, the access is a store and rdata=0.
- Word index = req_addr[IDX_W+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Misaligned request (req_addr[1:0] != 0):
  - No array access and no stall; rdata=0.
  - align_err=1 for every cycle the request is presented in IDLE. Combinational, so it is high for exactly one cycle when the pipeline advances.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned request, WAIT_STATES=0: stall=0; a load drives rdata = array[idx] combinationally; a store writes at the rising edge; stays in IDLE.
  - IDLE, aligned request, WAIT_STATES>0: stall=1 combinationally in that cycle (T). Next state is DONE if WAIT_STATES=1; otherwise BUSY with wcnt=WAIT_STATES-2.
  - BUSY: stall=1. If wcnt=0 go to DONE, else wcnt decrements.
  - DONE (cycle T+WAIT_STATES): stall=0; a load drives rdata = array[idx]; a store writes at the edge ending DONE. Always returns to IDLE.
  - Net effect: stall is high for exactly WAIT_STATES cycles per aligned access.
- rdata=0 in every cycle not completing a load.
- The array is only read or written in the completing cycle. Inputs in IDLE/BUSY are ignored except for the next-state decision.
- If the same request is still presented in IDLE after DONE (pipeline held by another hazard), it re-executes. This is idempotent and acceptable.
- Input change during BUSY is illegal upstream behaviour. The bench asserts it never happens.
- stall_cycles increments each cycle stall=1 and saturates at 0xFFFF_FFFF.
- Reset (asynchronous, reset=0):
  - state=IDLE, wcnt=0, stall_cycles=0.
  - Outputs read stall=0, align_err=0, rdata=0 while reset is asserted.
  - A store in flight is aborted and the array is unchanged.
  - Array contents are not reset (undefined until written).

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - WAIT_MAX=15;
  - word-alignment mask constant 2'b00.
- One sub-module, dmem_array: DEPTH_WORDS x 32, synchronous write enable, asynchronous read, no reset.
- FSM, counters and alignment check live in dmem_ctrl.

Test Plan:
1. WAIT_STATES=2. Store 0xDEADBEEF to 0x40 (held until stall=0), then load 0x40.
   Expect stall high for exactly 2 cycles per access, rdata=0xDEADBEEF in the load's DONE cycle, and stall_cycles=4.
2. WAIT_STATES=0. Store 0x12345678 to 0x0, then load 0x0 in the next cycle.
   Expect stall never asserted and rdata=0x12345678 in the same cycle as the load.
3. Load from 0x42.
   Expect align_err=1 for one cycle, stall=0, rdata=0, and array word 0x10 unchanged (prior value 0x0 readback).
4. DEPTH_WORDS=1024. Store 0xA5A5A5A5 to 0x1004, then load 0x0004.
   Expect rdata=0xA5A5A5A5 (aliasing).
5. WAIT_STATES=3. Assert reset=0 during BUSY of a store 0xFFFFFFFF to 0x80.
   Expect stall=0 immediately and stall_cycles=0. After release, the first load of 0x80 returns the previously written 0x11111111.
6. Both enables high: addr 0x8, wdata 0x55.
   Expect the write performed, rdata=0 throughout, and a subsequent load of 0x8 returns 0x55.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, limits and
// the word-alignment helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         WAIT_MAX   = 15;
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    function automatic logic word_aligned(input logic [1:0] byte_off);
        return (byte_off == ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: synchronous write, asynchronous read, no reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Storage write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: wait-state FSM that stalls the pipeline, misalignment
// flagging and a saturating stall-cycle counter around dmem_array.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read_en,
    input  logic        req_write_en,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        align_err,
    output logic [31:0] stall_cycles
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         WS_C      = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
    localparam bit         WS_ZERO   = (WS_C == 0);
    localparam bit         WS_ONE    = (WS_C == 1);
    localparam logic [3:0] WCNT_INIT = (WS_C >= 2) ? 4'(WS_C - 2) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_wcnt;
    logic [31:0]       r_stall_cycles;

    logic              w_req;
    logic              w_aligned;
    logic              w_active;
    logic              w_stall;
    logic              w_complete;
    logic              w_we;
    logic              w_load;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_arr_rdata;

    assign w_req     = req_read_en | req_write_en;
    assign w_aligned = word_aligned(req_addr[1:0]);
    assign w_active  = w_req & w_aligned;
    assign w_idx     = req_addr[IDX_W+1:2];

    // Stall and completion decode; everything is masked while reset is held.
    always_comb begin
        w_stall    = 1'b0;
        w_complete = 1'b0;
        if (!reset) begin
            w_stall    = 1'b0;
            w_complete = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_stall    = w_active & ~WS_ZERO;
                    w_complete = w_active & WS_ZERO;
                end
                ST_BUSY: w_stall    = 1'b1;
                ST_DONE: w_complete = w_active;
                default: begin
                    w_stall    = 1'b0;
                    w_complete = 1'b0;
                end
            endcase
        end
    end

    // A simultaneous read+write request is treated as a store.
    assign w_we   = w_complete & req_write_en;
    assign w_load = w_complete & ~req_write_en;

    assign rdata        = w_load ? w_arr_rdata : 32'h0000_0000;
    assign stall        = w_stall;
    assign align_err    = reset & (r_state == ST_IDLE) & w_req & ~w_aligned;
    assign stall_cycles = r_stall_cycles;

    // Wait-state sequencer: IDLE -> [BUSY x (WS-1)] -> DONE -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_active && !WS_ZERO) begin
                        r_state <= WS_ONE ? ST_DONE : ST_BUSY;
                        r_wcnt  <= WCNT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (r_wcnt == 4'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating performance counter of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 32'h0000_0000;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'h0000_0001;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_widx  (w_idx),
        .i_wdata (req_wdata),
        .i_ridx  (w_idx),
        .o_rdata (w_arr_rdata)
    );

endmodule
